// File: rtl/store_buffer.sv
// Write-back store buffer: FIFO of pending stores, drains to memory, forwards to hitting loads.
// Loads return in one cycle; stall is raised only for a load miss while full or draining.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        ex_addr,
  input  logic [DATA_W-1:0]        ex_write_data,
  input  logic                     ex_memwrite,
  input  logic                     ex_memread,
  input  logic                     drain_all,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_memwrite,
  output logic                     mem_memread,
  input  logic [DATA_W-1:0]        mem_read_data,
  output logic [DATA_W-1:0]        load_data,
  output logic                     load_valid,
  output logic                     stall,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              is_store;
  logic              is_load;
  logic              is_bad;
  logic              is_idle;
  logic              full;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  scan_idx;
  logic              drain;
  logic              load_rd;
  logic              load_acc;
  logic              push;
  logic              pop;

  assign is_store = ex_memwrite & ~ex_memread;
  assign is_load  = ex_memread & ~ex_memwrite;
  assign is_bad   = ex_memwrite & ex_memread;
  assign is_idle  = ~ex_memwrite & ~ex_memread;
  assign full     = (count_q == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (vld_q[scan_idx] && (addr_q[scan_idx] == ex_addr)) begin
        hit      = 1'b1;
        fwd_data = data_q[scan_idx];
      end
    end
  end

  // A load only gives up the port when the buffer must make room or is being flushed.
  assign drain    = (count_q != '0) & (is_idle | is_bad | full | drain_all);
  assign load_rd  = is_load & ~hit & ~full & ~drain_all;
  assign stall    = is_load & ~hit & (full | drain_all);
  assign load_acc = is_load & (hit | load_rd);
  assign push     = is_store;
  assign pop      = drain;

  always_comb begin
    mem_addr       = addr_q[head_q];
    mem_write_data = data_q[head_q];
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    if (!rst) begin
      if (drain) begin
        mem_memwrite = 1'b1;
      end else if (load_rd) begin
        mem_memread = 1'b1;
        mem_addr    = ex_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      // When full, push reuses the slot just popped; the push must win.
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= ex_addr;
      data_q[tail_q] <= ex_write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_data  <= '0;
      load_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      load_valid <= load_acc;
      err        <= is_bad;
      if (load_acc) begin
        load_data <= hit ? fwd_data : mem_read_data;
      end
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-back store buffer between the EX/MEM pipeline register and the word-addressed data memory.
- Queues up to DEPTH pending stores in FIFO order.
- Drains one store per cycle to memory when the memory port is free.
- Forwards buffered data to loads that hit a pending address; raises a stall when a load cannot be serviced.

Parameters:
DEPTH, 4, number of store entries; power of 2, ≥2
ADDR_W, 32, address width (word address, full-width compare)
DATA_W, 32, data width

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
ex_addr  input  ADDR_W  address from EX/MEM register
ex_write_data  input  DATA_W  store data from EX/MEM register
ex_memwrite  input  1  store request this cycle
ex_memread  input  1  load request this cycle
drain_all  input  1  force draining, e.g. before halt
mem_addr  output  ADDR_W  data-memory address, combinational
mem_write_data  output  DATA_W  data-memory write data, combinational
mem_memwrite  output  1  data-memory write strobe, combinational
mem_memread  output  1  data-memory read strobe, combinational
mem_read_data  input  DATA_W  data-memory read result, combinational in the same cycle
load_data  output  DATA_W  registered load result
load_valid  output  1  registered; 1 for one cycle when load_data is new
stall  output  1  combinational; hold EX/MEM, request not accepted
empty  output  1  count == 0
count  output  log2(DEPTH)+1  occupancy
err  output  1  registered; pulses when memwrite and memread are both 1

Behaviour:
- Reset (async, rst=1):
  - head, tail and count cleared to 0; all entries marked invalid.
  - load_data = 0, load_valid = 0, err = 0.
  - Memory strobes are 0 while rst is high.
  - A reset mid-drain discards all pending stores; stores are not written to memory.
- Storage: circular array of {addr, data}. Head and tail pointers wrap modulo DEPTH.
- Cycle classes, decided combinationally from inputs and count:
  - IDLE: neither request is active.
  - STORE: ex_memwrite=1 and ex_memread=0.
  - LOAD: ex_memread=1 and ex_memwrite=0.
  - BAD: both requests are 1. No push, no load, err=1 next cycle; drains as IDLE.
- Drain condition:
  - drain = (count>0) and (IDLE or BAD or full or drain_all).
  - full means count == DEPTH.
  - During a LOAD miss, drain is suppressed; the port is owned by the load.
- Drain cycle: mem_addr/mem_write_data = head entry, mem_memwrite=1, mem_memread=0. Head advances on the edge.
- STORE when not full: push at tail on the edge, stall=0.
- STORE when full: drain the head and push the new entry on the same edge; count unchanged, stall=0.
- LOAD, forwarding:
  - Compare ex_addr against all valid entries.
  - On one or more hits, the youngest (closest to tail) entry supplies the data. No memory access; stall=0.
  - load_data is captured on the edge with load_valid=1, so latency is 1 cycle.
  - A drain may proceed in a forwarding cycle only if full or drain_all.
- LOAD miss, not full and drain_all=0:
  - mem_addr=ex_addr, mem_memread=1, mem_memwrite=0.
  - mem_read_data is captured into load_data on the edge, load_valid=1, stall=0.
- LOAD miss when full or drain_all=1:
  - stall=1, the load is not accepted and load_valid stays 0.
  - The head drains; the load retries the next cycle.
- Memory strobes default to 0, with mem_addr and mem_write_data driven from the head entry. At most one strobe is high per cycle.
- load_valid is 0 in every cycle without an accepted load.
- Counter:
  - count += push − pop.
  - Push while count==DEPTH without a simultaneous pop is impossible by construction; assert it.
- Ordering: stores reach memory in program order. A load never returns data older than a buffered store to the same address.

Test Plan:
- Reset, then IDLE cycles -> count=0, empty=1, all mem strobes 0, load_valid=0, load_data=0.
- Stores (0x10,0xAAAA),(0x14,0xBBBB) back-to-back, then 2 IDLE -> count 1,2; then mem_memwrite with addr 0x10 data 0xAAAA, next cycle 0x14/0xBBBB; empty=1 after.
- Stores (0x20,1),(0x20,2), then LOAD 0x20 -> load_valid=1 next cycle with load_data=2, mem_memread=0.
- Store 4 distinct addresses (fill), store 5th (0x40,5) -> stall=0, head 0x30 written same cycle, count stays 4; then LOAD 0x99 miss -> stall=1 one cycle, drain occurs, retry reads memory.
- ex_memwrite=ex_memread=1 with count=0 -> no push, err=1 next cycle only, load_valid=0.
- Three stores pending, assert rst mid-drain -> count=0 immediately (async), no further mem_memwrite; a LOAD of a pending address reads memory, not stale buffer data.
